// File: rtl/experiment_controller.sv
// Aging-experiment sequencer: host command decode, operand/module registers, sensor FSM and readback.
// Optional EXP_CTRL_TIMESTAMP_EN adds a free-running cycle counter readable through code 1.
module experiment_controller #(
  parameter int unsigned NUM_MODULES  = 4,
  parameter int unsigned SEL_W        = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1,
  parameter int unsigned MEAS_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_code,
  input  logic [31:0]      cmd_data,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic [15:0]      op_x,
  output logic [15:0]      op_y,
  output logic [SEL_W-1:0] module_sel,
  output logic             dut_ena,
  output logic [1:0]       aging_mode,
  output logic             trigger_measurement,
  input  logic             aging_done,
  input  logic [31:0]      aging_value_in,
  input  logic [19:0]      result_in
);

  localparam int unsigned CNT_W = (MEAS_TIMEOUT > 2) ? $clog2(MEAS_TIMEOUT) : 1;

  localparam logic [2:0] CMD_WRITE_OP    = 3'd0;
  localparam logic [2:0] CMD_READ_TS     = 3'd1;
  localparam logic [2:0] CMD_READ_RESULT = 3'd2;
  localparam logic [2:0] CMD_TRIGGER     = 3'd3;
  localparam logic [2:0] CMD_READ_READY  = 3'd4;
  localparam logic [2:0] CMD_READ_AGING  = 3'd5;
  localparam logic [2:0] CMD_MODULE_SEL  = 3'd6;

  localparam logic [1:0] MODE_IDLE    = 2'd0;
  localparam logic [1:0] MODE_STRESS  = 2'd1;
  localparam logic [1:0] MODE_MEASURE = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_STRESS, S_MEASURE, S_CAPTURE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               stress_en;
  logic               ready_q;
  logic               timeout_q;
  logic [31:0]        aging_reg;
  logic [19:0]        result_reg;
  logic               accept;
  logic               sel_ok;
  logic               is_trigger;
  logic               is_msel;
  logic [1:0]         mode_d;
  logic               ena_d;
  logic               rdy_d;
  logic [31:0]        rsp_data_d;
  logic               rsp_err_d;
  logic               unused_bits;

`ifdef EXP_CTRL_TIMESTAMP_EN
  logic [31:0]        cyc_q;
  logic [31:0]        ts_reg;
`endif

  assign accept      = cmd_valid && cmd_ready;
  assign sel_ok      = 32'(cmd_data[7:0]) < 32'(NUM_MODULES);
  assign is_trigger  = accept && (cmd_code == CMD_TRIGGER);
  assign is_msel     = accept && (cmd_code == CMD_MODULE_SEL);
  assign unused_bits = ^cmd_data[30:17];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_STRESS: begin
        if (is_trigger)            state_d = S_MEASURE;
        else if (is_msel && sel_ok) state_d = cmd_data[31] ? S_STRESS : S_IDLE;
      end
      S_MEASURE: if (aging_done || cnt_q == '0) state_d = S_CAPTURE;
      S_CAPTURE: state_d = stress_en ? S_STRESS : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the port copies stay registered
  always_comb begin
    mode_d = MODE_IDLE;
    ena_d  = 1'b0;
    rdy_d  = 1'b0;
    unique case (state_d)
      S_IDLE:    rdy_d = 1'b1;
      S_STRESS:  begin mode_d = MODE_STRESS;  ena_d = 1'b1; rdy_d = 1'b1; end
      S_MEASURE: begin mode_d = MODE_MEASURE; ena_d = 1'b1; end
      S_CAPTURE: begin mode_d = MODE_MEASURE; ena_d = 1'b1; end
      default:   rdy_d = 1'b0;
    endcase
  end

  // Response decode for the command being accepted
  always_comb begin
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    unique case (cmd_code)
      CMD_WRITE_OP, CMD_TRIGGER: rsp_data_d = '0;
      CMD_READ_RESULT: rsp_data_d = {12'b0, result_reg};
      CMD_READ_READY:  rsp_data_d = {30'b0, timeout_q, ready_q};
      CMD_READ_AGING:  rsp_data_d = aging_reg;
      CMD_MODULE_SEL:  rsp_err_d  = !sel_ok;
`ifdef EXP_CTRL_TIMESTAMP_EN
      CMD_READ_TS:     rsp_data_d = ts_reg;
`else
      CMD_READ_TS:     rsp_err_d  = 1'b1;
`endif
      default:         rsp_err_d  = 1'b1;
    endcase
  end

  // Registered outputs, operand/select registers and measurement datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready           <= 1'b0;
      aging_mode          <= MODE_IDLE;
      dut_ena             <= 1'b0;
      rsp_valid           <= 1'b0;
      rsp_data            <= '0;
      rsp_err             <= 1'b0;
      op_x                <= '0;
      op_y                <= '0;
      module_sel          <= '0;
      stress_en           <= 1'b0;
      trigger_measurement <= 1'b0;
      cnt_q               <= '0;
      ready_q             <= 1'b0;
      timeout_q           <= 1'b0;
      aging_reg           <= '0;
      result_reg          <= '0;
    end else begin
      cmd_ready           <= rdy_d;
      aging_mode          <= mode_d;
      dut_ena             <= ena_d;
      rsp_valid           <= accept;
      rsp_data            <= accept ? rsp_data_d : '0;
      rsp_err             <= accept && rsp_err_d;
      trigger_measurement <= is_trigger;

      if (accept && cmd_code == CMD_WRITE_OP) begin
        if (cmd_data[16]) op_y <= cmd_data[15:0];
        else              op_x <= cmd_data[15:0];
      end

      if (is_msel && sel_ok) begin
        module_sel <= cmd_data[SEL_W-1:0];
        stress_en  <= cmd_data[31];
      end

      if (is_trigger) begin
        ready_q   <= 1'b0;
        timeout_q <= 1'b0;
        cnt_q     <= CNT_W'(MEAS_TIMEOUT - 1);
      end else if (state_q == S_MEASURE && !aging_done) begin
        if (cnt_q == '0) timeout_q <= 1'b1;
        else             cnt_q     <= cnt_q - CNT_W'(1);
      end

      if (state_q == S_CAPTURE) begin
        aging_reg  <= aging_value_in;
        result_reg <= result_in;
        ready_q    <= 1'b1;
      end
    end
  end

`ifdef EXP_CTRL_TIMESTAMP_EN
  // Free-running cycle counter, sampled on the first measurement cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= '0;
      ts_reg <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (trigger_measurement) ts_reg <= cyc_q;
    end
  end
`endif

endmodule
